jtag_dump_unit: RTL and testbench
=================================

Name: jtag_dump_unit

Overview:
- Serial-out counterpart of the Jin word loader: streams data memory and then instruction memory out on Jout, one 32-bit word per clock.
- Words leave in the same order the loader consumes them: data memory from address 511 down to 0, then instruction memory from 511 down to 0. A captured dump can therefore be replayed directly into Jin.
- Sits beside the loader at the top level.
- Reads both memories through a pipelined read port, and buffers words in a credit-managed FIFO so that host back-pressure never drops a word.

Parameters:
- WORDS, 512, words per memory.
- ADDR_W, 9, memory address width.
- DATA_W, 32, word width.
- DEPTH, 4, output FIFO entries; this is also the maximum number of reads in flight.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- Jen  input  1  loader active; aborts any dump in progress.
- start  input  1  single-cycle request to begin a dump.
- rd_req  output  1  memory read strobe.
- rd_sel  output  1  memory select: 0 = data memory, 1 = instruction memory.
- rd_addr  output  ADDR_W  read address.
- rd_valid  input  1  read data returned; responses come back in order.
- rd_data  input  DATA_W  returned word.
- Jout  output  DATA_W  head word of the dump stream.
- Jout_valid  output  1  Jout holds a valid word.
- Jout_ready  input  1  host accepts the word on Jout.
- busy  output  1  a dump is in progress.
- done  output  1  single-cycle pulse when a dump completes.
- proto_err  output  1  sticky flag: rd_valid arrived with zero reads outstanding.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - rd_req, rd_sel, rd_addr, Jout, Jout_valid, busy, done, proto_err = 0.
  - FIFO empty, outstanding count = 0, state = IDLE.
- States and transitions:
  - IDLE → READ_D on start && !Jen. Entry sets rd_addr = WORDS-1, rd_sel = 0, busy = 1 from the next cycle.
  - READ_D: issue reads. After the read of address 0 is issued → READ_I with rd_addr = WORDS-1, rd_sel = 1.
  - READ_I: issue reads. After the read of address 0 is issued → DRAIN.
  - DRAIN: wait until outstanding == 0 && FIFO empty → DONE.
  - DONE: done = 1 for exactly one cycle, busy drops in the same cycle, then → IDLE.
- Read issue rule:
  - rd_req = 1 in a READ state when (outstanding + fifo_count) < DEPTH.
  - rd_addr decrements after every issued read.
  - rd_sel and rd_addr are registered and stable whenever rd_req is high.
- Reads in flight:
  - outstanding increments on an issued read and decrements on rd_valid.
  - Simultaneous issue and return leaves the count unchanged.
- FIFO behaviour:
  - rd_valid pushes rd_data into the FIFO. The credit rule guarantees the FIFO never overflows.
  - Jout_valid = FIFO not empty; Jout = FIFO head.
  - Pop on Jout_valid && Jout_ready.
  - Jout and Jout_valid hold stable while Jout_ready is low.
  - Push and pop in the same cycle are allowed at any fill level, including full.
- Throughput and latency:
  - With Jout_ready held high and 1-cycle read latency, the stream runs one word per cycle after fill.
  - First Jout_valid appears 3 cycles after start: 1 cycle to issue, 1 cycle memory latency, 1 cycle FIFO write.
- Word count: exactly 2*WORDS words are emitted per dump.
- start while busy is ignored.
- Jen high in any non-IDLE state (abort):
  - next cycle: state = IDLE, FIFO flushed, Jout_valid = 0, no done pulse.
  - outstanding keeps counting returns; responses arriving after the abort are discarded.
  - A new start is accepted only once outstanding == 0.
- proto_err:
  - set by rd_valid with outstanding == 0, outside the post-abort discard window.
  - cleared only by rst.
- Reset mid-dump returns everything to the reset values immediately.
- Counters use ADDR_W+1 bits so that address 0 is detected without wrap-around.

Decomposition:
- Shared package jtag_pkg holds:
  - WORDS, ADDR_W, DATA_W;
  - state enum {IDLE, READ_D, READ_I, DRAIN, DONE};
  - MEM_DATA = 0 and MEM_INST = 1 select constants.
- One sub-module: sync_fifo, parameterised by DEPTH and width, with push, pop, full, empty and count outputs.
- The state machine, credit counter and address counter stay in the top-level module.

Test Plan:
- Full dump at line rate: data[i] = 0x1000+i, instr[i] = 0x2000+i, Jout_ready = 1, 1-cycle memory → 1024 words, order 0x11FF..0x1000 then 0x21FF..0x2000; done pulses once, 1 cycle after the last pop; busy is high throughout.
- Back-pressure: Jout_ready toggles 1,0,0,1 repeatedly → no word lost or duplicated; Jout is stable while stalled; rd_req never issues beyond 4 in flight.
- Variable memory latency of 3 cycles → order is unchanged and all 1024 words arrive; outstanding peaks at 4.
- Abort: Jen = 1 after word 100 → Jout_valid = 0 next cycle, no done; a start issued while reads are still pending is ignored; once outstanding == 0, start restarts from data address 511.
- start pulses during busy, and start with Jen = 1 in IDLE → ignored; the word count stays 1024 and the sequence is unchanged.
- Spurious rd_valid in IDLE → proto_err = 1 and stays set until rst. Asserting rst mid-dump → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/jtag_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared constants and types for the JTAG dump unit.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    localparam int WORDS  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    // Memory select encodings on rd_sel
    localparam logic MEM_DATA = 1'b0;
    localparam logic MEM_INST = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_D = 3'd1,
        READ_I = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_dump_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO; push and pop may coincide at any fill
//               level, including full. flush empties it in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == c_FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO may still accept
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : jtag_dump_unit
// Description : Streams data memory (511..0) then instruction memory
//               (511..0) out on Jout, one word per cycle, in Jin load order.
//               Reads are credit-limited so the output FIFO never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_dump_unit
    import jtag_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Jen,
    input  logic              start,
    output logic              rd_req,
    output logic              rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] Jout,
    output logic              Jout_valid,
    input  logic              Jout_ready,
    output logic              busy,
    output logic              done,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  c_CREDITS  = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_TOP_ADDR = (ADDR_W + 1)'(WORDS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_addr_cnt;
    logic [ADDR_W:0]   w_addr_next;
    logic              r_sel;
    logic              w_sel_next;
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_proto_err;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;
    logic [CNT_W:0]    w_in_use;
    logic              w_reading;
    logic              w_active;
    logic              w_abort;
    logic              w_issue;
    logic              w_ret;
    logic              w_push;
    logic              w_pop;
    logic              w_last_addr;

    assign w_reading   = (r_state == READ_D) || (r_state == READ_I);
    assign w_active    = w_reading || (r_state == DRAIN);
    assign w_abort     = Jen && (r_state != IDLE);
    assign w_in_use    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_issue     = w_reading && !Jen && (w_in_use < c_CREDITS);
    assign w_ret       = rd_valid && (r_outstanding != '0);
    // Returns after an abort are counted but not stored
    assign w_push      = w_ret && w_active && (!w_fifo_full || w_pop);
    assign w_pop       = !w_fifo_empty && Jout_ready;
    assign w_last_addr = (r_addr_cnt == '0);

    assign rd_req     = w_issue;
    assign rd_sel     = r_sel;
    assign rd_addr    = r_addr_cnt[ADDR_W-1:0];
    assign Jout_valid = !w_fifo_empty;
    assign Jout       = w_fifo_empty ? '0 : w_fifo_head;
    assign busy       = w_active;
    assign done       = (r_state == DONE);
    assign proto_err  = r_proto_err;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_abort),
        .push      (w_push),
        .push_data (rd_data),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // State, address and memory-select registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr_cnt <= '0;
            r_sel      <= MEM_DATA;
        end else begin
            r_state    <= w_state_next;
            r_addr_cnt <= w_addr_next;
            r_sel      <= w_sel_next;
        end
    end

    // Next-state and address sequencing; abort overrides everything
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr_cnt;
        w_sel_next   = r_sel;
        case (r_state)
            IDLE: begin
                if (start && !Jen && (r_outstanding == '0)) begin
                    w_state_next = READ_D;
                    w_addr_next  = c_TOP_ADDR;
                    w_sel_next   = MEM_DATA;
                end
            end
            READ_D: begin
                if (w_issue) begin
                    if (w_last_addr) begin
                        w_state_next = READ_I;
                        w_addr_next  = c_TOP_ADDR;
                        w_sel_next   = MEM_INST;
                    end else begin
                        w_addr_next  = r_addr_cnt - 1'b1;
                    end
                end
            end
            READ_I: begin
                if (w_issue) begin
                    if (w_last_addr) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_addr_next  = r_addr_cnt - 1'b1;
                    end
                end
            end
            DRAIN: begin
                if ((r_outstanding == '0) && w_fifo_empty) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_abort) begin
            w_state_next = IDLE;
        end
    end

    // Reads in flight: up on issue, down on return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky flag for a read return nobody asked for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (rd_valid && (r_outstanding == '0)) begin
            r_proto_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_dump_unit
// Description : Scoreboard bench for jtag_dump_unit with a latency-
//               configurable memory model and host back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Jen;
    logic        start;
    logic        rd_req;
    logic        rd_sel;
    logic [8:0]  rd_addr;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data  = 32'h0;
    logic [31:0] Jout;
    logic        Jout_valid;
    logic        Jout_ready;
    logic        busy;
    logic        done;
    logic        proto_err;

    jtag_dump_unit #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Jen        (Jen),
        .start      (start),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .Jout       (Jout),
        .Jout_valid (Jout_valid),
        .Jout_ready (Jout_ready),
        .busy       (busy),
        .done       (done),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          words_rx, issued, popped, peak;
    int          done_cnt, done_cyc, last_pop_cyc, first_valid_cyc, t0;
    bit          first_pending = 1'b0;
    int          lat   = 1;
    int          rmode = 0;
    int          phase = 0;
    bit          spur_req = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t pend[$];

    // Memory model: in-order responses after lat cycles; data = base + address
    always @(negedge clk) begin
        #2;
        rd_valid = 1'b0;
        if (spur_req) begin
            rd_valid = 1'b1;
            rd_data  = 32'hDEAD_BEEF;
            spur_req = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = pend[0].data;
            pend.delete(0);
        end
        if (rd_req && !rst) begin
            pend.push_back('{cyc + lat, (rd_sel ? 32'h2000 : 32'h1000) + 32'(rd_addr)});
        end
    end

    // Host ready: always 1, or the repeating pattern 1,0,0,1
    always @(negedge clk) begin
        if (rmode == 0) begin
            Jout_ready = 1'b1;
        end else begin
            Jout_ready = (phase == 0) || (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        #3;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!Jout_valid || Jout !== prev_word) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b Jout=%h, required valid=1 Jout=%h", Jout_valid, Jout, prev_word);
                end
            end
            if (rd_req) begin
                checks++;
                if (issued - popped >= 4) begin
                    errors++;
                    $display("FAIL credit: read issued with %0d in use, required < 4", issued - popped);
                end
                issued++;
            end
            if (Jout_valid && Jout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %h, required no word", Jout);
                end else begin
                    logic [31:0] ew;
                    ew = exp_q.pop_front();
                    if (Jout !== ew) begin
                        errors++;
                        $display("FAIL word_%0d: got %h, required %h", words_rx, Jout, ew);
                    end
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_word: got %b, required 1", busy);
                end
                words_rx++;
                popped++;
                last_pop_cyc = cyc;
            end
            if (issued - popped > peak) peak = issued - popped;
            if (Jout_valid && first_pending) begin
                first_valid_cyc = cyc;
                first_pending   = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = Jout_valid && !Jout_ready;
            prev_word  = Jout;
        end
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [46:0] out_vec();
        return {rd_req, rd_sel, rd_addr, Jout, Jout_valid, busy, done, proto_err};
    endfunction

    task automatic prep_dump();
        words_rx = 0; issued = 0; popped = 0; peak = 0; done_cnt = 0;
        exp_q.delete();
        for (int i = 511; i >= 0; i--) exp_q.push_back(32'h1000 + 32'(i));
        for (int i = 511; i >= 0; i--) exp_q.push_back(32'h2000 + 32'(i));
        first_pending = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n0;
        bit got;
        n0  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #4;
            if (done_cnt != n0) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done pulse", name, max_cyc);
        end
    endtask

    task automatic finish_dump(input string name, input bit chk_lat);
        repeat (3) @(negedge clk);
        check_eq({name, "_word_count"}, 64'(words_rx), 64'd1024);
        check_eq({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check_eq({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        checks++;
        if (done_cyc - last_pop_cyc < 1 || done_cyc - last_pop_cyc > 2) begin
            errors++;
            $display("FAIL %s_done_timing: got %0d cycles after last pop, required 1..2", name, done_cyc - last_pop_cyc);
        end
        if (chk_lat) check_eq({name, "_first_valid_latency"}, 64'(first_valid_cyc - t0), 64'd3);
    endtask

    task automatic run_dump(input string name, input int l, input int mode, input bit pulses);
        lat = l; rmode = mode; phase = 0;
        prep_dump();
        do_start();
        check_eq({name, "_busy_after_start"}, 64'(busy), 64'd1);
        if (pulses) begin
            repeat (40) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
            repeat (300) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
        end
        wait_done(6000, name);
        finish_dump(name, l == 1);
    endtask

    task automatic wait_words(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (words_rx >= n) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_words: got %0d words, required %0d", words_rx, n);
        end
    endtask

    task automatic wait_drained();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #3;
            if (pend.size() == 0 && !rd_valid) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drain: %0d reads still pending, required 0", pend.size());
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; Jen = 1'b0; start = 1'b0; Jout_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_outputs", 64'(out_vec()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full dump at line rate
        run_dump("line_rate", 1, 0, 1'b0);
        check_eq("line_rate_proto_err", 64'(proto_err), 64'd0);

        // Host back-pressure 1,0,0,1
        run_dump("backpressure", 1, 1, 1'b0);

        // Memory latency of 3 cycles
        run_dump("latency3", 3, 0, 1'b0);
        check_eq("latency3_inflight_peak", 64'(peak), 64'd4);

        // Abort after word 100, start while reads pending, then restart
        lat = 3; rmode = 0;
        prep_dump();
        do_start();
        wait_words(100);
        Jen = 1'b1;
        @(negedge clk);
        Jen = 1'b0;
        exp_q.delete();
        check_eq("abort_valid_low", 64'(Jout_valid), 64'd0);
        check_eq("abort_busy_low", 64'(busy), 64'd0);
        check_eq("abort_reads_pending", 64'(pend.size() > 0), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_while_pending_ignored", 64'(busy), 64'd0);
        wait_drained();
        check_eq("abort_no_done", 64'(done_cnt), 64'd0);
        check_eq("abort_no_proto_err", 64'(proto_err), 64'd0);
        run_dump("after_abort", 3, 0, 1'b0);

        // start with Jen high in IDLE, then start pulses while busy
        @(negedge clk);
        Jen = 1'b1; start = 1'b1;
        @(negedge clk);
        Jen = 1'b0; start = 1'b0;
        check_eq("start_with_jen_ignored", 64'(busy), 64'd0);
        run_dump("start_pulses", 1, 0, 1'b1);

        // Spurious return in IDLE, then reset mid-dump
        @(negedge clk);
        spur_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("proto_err_set", 64'(proto_err), 64'd1);
        repeat (5) @(negedge clk);
        check_eq("proto_err_sticky", 64'(proto_err), 64'd1);
        lat = 1; rmode = 0;
        prep_dump();
        do_start();
        repeat (60) @(negedge clk);
        rst = 1'b1;
        pend.delete();
        #1;
        check_eq("reset_mid_dump", 64'(out_vec()), 64'd0);
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("proto_err_after_rst", 64'(proto_err), 64'd0);
        check_eq("idle_after_rst", 64'({busy, Jout_valid, rd_req}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
